mwave_sequencer: RTL and testbench
==================================

# mwave_sequencer

Clocked cook-cycle sequencer for the microwave oven's magnetron control path. It accepts keypad time entry and the active-low start/stop/clear buttons, counts the cook time down as MM:SS in BCD, and drives `mag_on` and `timer_done` for the magnetron stage and the display. It is the synchronous replacement for the button-to-latch magnetron enable: the SR latch is removed and all decisions are made in one FSM on `clk`.

## Interface
- `BEEP_TICKS`, 3: number of `tick_1hz` pulses `beep` stays high after cook end (1..15).
- `clk` input 1: system clock; all state changes on rising edge.
- `reset` input 1: synchronous, active-high reset.
- `tick_1hz` input 1: one-`clk`-wide pulse, once per second.
- `startn`, `stopn`, `clearn` input 1 each: active-low button levels, already debounced.
- `door_closed` input 1: 1 = door closed.
- `key_valid` input 1: one-cycle strobe, `key_digit` valid.
- `key_digit` input 4: BCD digit 0..9.
- `min_tens`, `min_ones`, `sec_tens`, `sec_ones` output 4 each: BCD display of remaining or entered time.
- `state` output 3: IDLE=0, SET=1, COOKING=2, PAUSED=3, DONE=4.
- `mag_on` output 1: magnetron enable.
- `timer_done` output 1: high while in DONE.
- `beep` output 1: end-of-cook buzzer.

## Operation
- Button press = falling edge of the level: registered previous value is 1, current value is 0. Previous-value registers reset to 1. A held button produces exactly one press.
- Same-cycle priority: clear > stop > start > key.
- Clear press, any state: state IDLE, all four digits 0, `beep` 0.
- Key entry (`key_valid`, digit <= 9), only in IDLE or SET: shift left: min_tens<=min_ones, min_ones<=sec_tens, sec_tens<=sec_ones, sec_ones<=key_digit. State becomes SET. Digits 10..15 are ignored. Keys in other states are ignored.
- Start press in IDLE/SET: goes to COOKING only if `door_closed`=1 and time != 00:00. Otherwise it is ignored.
- Start press in PAUSED with `door_closed`=1: goes to COOKING and keeps the remaining time.
- COOKING:
  - On `tick_1hz`, decrement BCD MM:SS.
    - sec_ones 0 → 9 with sec_tens borrow.
    - seconds 00 → 59 with minute borrow.
    - Entered seconds 60..99 count down literally (99, 98, ...).
  - A tick that makes the time 00:00 enters DONE on the same edge.
  - Stop press → PAUSED.
  - `door_closed`=0 → PAUSED. This takes priority over a same-cycle tick: no decrement.
- Stop press in PAUSED: IDLE, digits cleared.
- DONE: `beep`=1 for `BEEP_TICKS` ticks, then 0. Exit to IDLE (digits already 0) on a stop press, a clear press, or `door_closed`=0.
- `tick_1hz` outside COOKING has no effect (except the beep count in DONE).
- `mag_on` = (state==COOKING) & `door_closed`. This is combinational gating, so door opening drops `mag_on` in the same cycle.
- `timer_done` = (state==DONE).

## Timing
- Reset values: state IDLE, all digits 0, `mag_on` 0, `timer_done` 0, `beep` 0, button history 1.
- Reset mid-cook: `mag_on` low after the reset edge. The reset value persists while `reset`=1.
- Button press to state change: 1 clock after the first sampled low level (edge detect register, then state register).
- Tick to display update: the digits change on the edge sampling `tick_1hz`=1.
- 00:01 + tick: digits 00:00 and state DONE on the same edge. `mag_on` falls and `timer_done` rises after that edge.
- Door opening in COOKING: `mag_on` falls in the same cycle (combinational). State is PAUSED at the next edge.

## Configuration
- `MWAVE_BEEP_EN` defined:
  - beep counter (ceil(log2(BEEP_TICKS+1)) bits) is built.
  - `beep` behaves as in Operation.
- `MWAVE_BEEP_EN` undefined:
  - no counter is built.
  - `beep` is tied to 0.
  - all other behaviour, including DONE entry and exit, is unchanged.

## Test plan
- Reset, then keys 1,3,0 and start with the door closed: display 01:30 and state SET → COOKING. After 90 ticks the display reads 00:00, state DONE, `timer_done`=1, and `mag_on` goes 1 → 0.
- Keys 5,9 cooking: 6 ticks pass through 00:54, 00:53; 59 ticks reach DONE. In a separate run, 1,0,0 (01:00) plus one tick gives 00:59.
- During COOKING at 00:40, `door_closed`=0 with a simultaneous tick: `mag_on`=0 in the same cycle, PAUSED, still 00:40. Close the door and press start: COOKING resumes from 00:40.
- Start pressed with 00:00 or with the door open: stays IDLE/SET and `mag_on` stays 0. Hold `startn` low for 10 cycles after a valid start: only one transition occurs.
- Clear and start in the same cycle during SET 02:00: IDLE, 00:00. Stop twice from COOKING: PAUSED, then IDLE with 00:00.
- With `MWAVE_BEEP_EN`, `BEEP_TICKS`=3: `beep` high exactly 3 ticks after DONE. Without the macro: `beep` is always 0. `reset` asserted mid-COOKING: IDLE, 00:00, `mag_on`=0 after the edge.

Source files
------------

// File: rtl/mwave_sequencer.sv
// Cook-cycle sequencer for the microwave magnetron path: keypad entry, BCD MM:SS countdown,
// magnetron gating and end-of-cook buzzer. Define MWAVE_BEEP_EN to build the beep counter.
module mwave_sequencer #(
  parameter int unsigned BEEP_TICKS = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       startn,
  input  logic       stopn,
  input  logic       clearn,
  input  logic       door_closed,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic [2:0] state,
  output logic       mag_on,
  output logic       timer_done,
  output logic       beep
);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StSet     = 3'd1,
    StCooking = 3'd2,
    StPaused  = 3'd3,
    StDone    = 3'd4
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] mt_q, mt_d, mo_q, mo_d, st_q, st_d, so_q, so_d;

  // Buttons are sampled once, then compared with the previous sample: {clear, stop, start}.
  logic [2:0] btn_q, btn_prev_q;
  logic       clear_press, stop_press, start_press;

  logic [3:0] dec_mt, dec_mo, dec_st, dec_so;
  logic       dec_zero, time_zero, key_ok;

  assign clear_press = btn_prev_q[2] & ~btn_q[2];
  assign stop_press  = btn_prev_q[1] & ~btn_q[1];
  assign start_press = btn_prev_q[0] & ~btn_q[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      mt_q       <= 4'd0;
      mo_q       <= 4'd0;
      st_q       <= 4'd0;
      so_q       <= 4'd0;
      btn_q      <= 3'b111;
      btn_prev_q <= 3'b111;
    end else begin
      state_q    <= state_d;
      mt_q       <= mt_d;
      mo_q       <= mo_d;
      st_q       <= st_d;
      so_q       <= so_d;
      btn_q      <= {clearn, stopn, startn};
      btn_prev_q <= btn_q;
    end
  end

  // One-second BCD decrement; seconds above 59 simply count down digit-wise.
  always_comb begin
    dec_mt = mt_q;
    dec_mo = mo_q;
    dec_st = st_q;
    dec_so = so_q;
    if (so_q != 4'd0) begin
      dec_so = so_q - 4'd1;
    end else begin
      dec_so = 4'd9;
      if (st_q != 4'd0) begin
        dec_st = st_q - 4'd1;
      end else begin
        dec_st = 4'd5;
        if (mo_q != 4'd0) begin
          dec_mo = mo_q - 4'd1;
        end else begin
          dec_mo = 4'd9;
          dec_mt = mt_q - 4'd1;
        end
      end
    end
  end

  assign dec_zero  = ({dec_mt, dec_mo, dec_st, dec_so} == 16'h0000);
  assign time_zero = ({mt_q, mo_q, st_q, so_q} == 16'h0000);
  assign key_ok    = key_valid && (key_digit <= 4'd9);

  always_comb begin
    state_d = state_q;
    mt_d    = mt_q;
    mo_d    = mo_q;
    st_d    = st_q;
    so_d    = so_q;
    if (clear_press) begin
      state_d = StIdle;
      mt_d    = 4'd0;
      mo_d    = 4'd0;
      st_d    = 4'd0;
      so_d    = 4'd0;
    end else begin
      case (state_q)
        StIdle, StSet: begin
          // A stop press has no effect here but still outranks start and key.
          if (stop_press) begin
            state_d = state_q;
          end else if (start_press) begin
            if (door_closed && !time_zero) state_d = StCooking;
          end else if (key_ok) begin
            mt_d    = mo_q;
            mo_d    = st_q;
            st_d    = so_q;
            so_d    = key_digit;
            state_d = StSet;
          end
        end
        StCooking: begin
          // Door opening wins over a same-cycle tick so no second is lost.
          if (stop_press || !door_closed) begin
            state_d = StPaused;
          end else if (tick_1hz) begin
            mt_d = dec_mt;
            mo_d = dec_mo;
            st_d = dec_st;
            so_d = dec_so;
            if (dec_zero) state_d = StDone;
          end
        end
        StPaused: begin
          if (stop_press) begin
            state_d = StIdle;
            mt_d    = 4'd0;
            mo_d    = 4'd0;
            st_d    = 4'd0;
            so_d    = 4'd0;
          end else if (start_press && door_closed) begin
            state_d = StCooking;
          end
        end
        StDone: begin
          if (stop_press || !door_closed) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign min_tens   = mt_q;
  assign min_ones   = mo_q;
  assign sec_tens   = st_q;
  assign sec_ones   = so_q;
  assign state      = state_q;
  assign mag_on     = (state_q == StCooking) && door_closed;
  assign timer_done = (state_q == StDone);

`ifdef MWAVE_BEEP_EN
  localparam int unsigned BeepW = $clog2(BEEP_TICKS + 1);
  localparam logic [BeepW-1:0] BeepMax = BeepW'(BEEP_TICKS);

  logic [BeepW-1:0] beep_cnt_q;

  // Counts ticks spent in DONE; held at zero elsewhere so each DONE entry restarts it.
  always_ff @(posedge clk) begin
    if (reset || (state_q != StDone)) begin
      beep_cnt_q <= '0;
    end else if (tick_1hz && (beep_cnt_q != BeepMax)) begin
      beep_cnt_q <= beep_cnt_q + 1'b1;
    end
  end

  assign beep = (state_q == StDone) && (beep_cnt_q != BeepMax);
`else
  logic unused_beep_cfg;
  assign unused_beep_cfg = (BEEP_TICKS == 0);
  assign beep            = 1'b0;
`endif

endmodule

// File: tb/tb_mwave_sequencer.sv
// Directed-vector bench for mwave_sequencer; expected values are hand-computed constants.
module tb_mwave_sequencer;

  logic       clk = 1'b0;
  logic       reset, tick_1hz, startn, stopn, clearn, door_closed, key_valid;
  logic [3:0] key_digit;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic [2:0] state;
  logic       mag_on, timer_done, beep;

  int n_tests = 0;
  int n_fail  = 0;

  mwave_sequencer #(.BEEP_TICKS(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .tick_1hz   (tick_1hz),
    .startn     (startn),
    .stopn      (stopn),
    .clearn     (clearn),
    .door_closed(door_closed),
    .key_valid  (key_valid),
    .key_digit  (key_digit),
    .min_tens   (min_tens),
    .min_ones   (min_ones),
    .sec_tens   (sec_tens),
    .sec_ones   (sec_ones),
    .state      (state),
    .mag_on     (mag_on),
    .timer_done (timer_done),
    .beep       (beep)
  );

  always #5 clk = ~clk;

  wire [15:0] disp = {min_tens, min_ones, sec_tens, sec_ones};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic key(input logic [3:0] d);
    key_valid = 1'b1;
    key_digit = d;
    cyc();
    key_valid = 1'b0;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      tick_1hz = 1'b1;
      cyc();
      tick_1hz = 1'b0;
      cyc();
    end
  endtask

  // Low for two edges (sample, then act), then release.
  task automatic press_start();
    startn = 1'b0; cyc(); cyc(); startn = 1'b1; cyc();
  endtask

  task automatic press_stop();
    stopn = 1'b0; cyc(); cyc(); stopn = 1'b1; cyc();
  endtask

  task automatic press_clear();
    clearn = 1'b0; cyc(); cyc(); clearn = 1'b1; cyc();
  endtask

  int changes;
  logic [2:0] last_state;

  initial begin
    reset = 1'b1; tick_1hz = 1'b0; startn = 1'b1; stopn = 1'b1; clearn = 1'b1;
    door_closed = 1'b1; key_valid = 1'b0; key_digit = 4'd0;
    cyc(); cyc();
    check("rst_state", state, 0);
    check("rst_disp", disp, 16'h0000);
    check("rst_mag", mag_on, 0);
    check("rst_done", timer_done, 0);
    check("rst_beep", beep, 0);
    reset = 1'b0;
    cyc();

    // 01:30 full countdown
    key(4'd1); key(4'd3); key(4'd0);
    check("set_disp", disp, 16'h0130);
    check("set_state", state, 1);
    press_start();
    check("cook_state", state, 2);
    check("cook_mag", mag_on, 1);
    tick(1);
    check("tick1", disp, 16'h0129);
    tick(88);
    check("at_0001", disp, 16'h0001);
    check("at_0001_state", state, 2);
    tick_1hz = 1'b1; cyc(); tick_1hz = 1'b0;
    check("done_disp", disp, 16'h0000);
    check("done_state", state, 4);
    check("done_flag", timer_done, 1);
    check("done_mag", mag_on, 0);
    cyc();
`ifdef MWAVE_BEEP_EN
    check("beep_t0", beep, 1);
    tick(1); check("beep_t1", beep, 1);
    tick(1); check("beep_t2", beep, 1);
    tick(1); check("beep_t3", beep, 0);
    tick(1); check("beep_t4", beep, 0);
`else
    check("beep_off0", beep, 0);
    tick(4); check("beep_off1", beep, 0);
`endif
    press_stop();
    check("done_exit", state, 0);
    check("done_exit_flag", timer_done, 0);

    // 00:59 countdown
    key(4'd5); key(4'd9);
    check("k59", disp, 16'h0059);
    press_start();
    tick(5); check("t0054", disp, 16'h0054);
    tick(1); check("t0053", disp, 16'h0053);
    tick(53);
    check("t59_state", state, 4);
    check("t59_disp", disp, 16'h0000);
    press_clear();
    check("clr_done", state, 0);

    // Minute borrow, then door open at 00:40 with simultaneous tick
    key(4'd1); key(4'd0); key(4'd0);
    check("k100", disp, 16'h0100);
    press_start();
    tick(1); check("t0059b", disp, 16'h0059);
    tick(19); check("t0040", disp, 16'h0040);
    door_closed = 1'b0; tick_1hz = 1'b1; #1;
    check("door_mag_comb", mag_on, 0);
    cyc(); tick_1hz = 1'b0;
    check("door_pause", state, 3);
    check("door_hold", disp, 16'h0040);
    tick(2);
    check("pause_tick", disp, 16'h0040);
    door_closed = 1'b1;
    press_start();
    check("resume_state", state, 2);
    check("resume_disp", disp, 16'h0040);
    check("resume_mag", mag_on, 1);

    // Stop twice
    press_stop();
    check("stop1", state, 3);
    check("stop1_mag", mag_on, 0);
    press_stop();
    check("stop2", state, 0);
    check("stop2_disp", disp, 16'h0000);

    // Rejected starts
    press_start();
    check("start_zero", state, 0);
    check("start_zero_mag", mag_on, 0);
    key(4'd12);
    check("key_bad", state, 0);
    key(4'd2);
    check("k2", disp, 16'h0002);
    door_closed = 1'b0;
    press_start();
    check("start_open", state, 1);
    check("start_open_mag", mag_on, 0);
    door_closed = 1'b1;

    // Held start gives one transition
    startn = 1'b0;
    changes = 0;
    last_state = state;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (state != last_state) changes++;
      last_state = state;
    end
    startn = 1'b1; cyc();
    check("hold_changes", changes, 1);
    check("hold_state", state, 2);

    // Clear beats start
    press_clear();
    key(4'd2); key(4'd0); key(4'd0);
    check("k200", disp, 16'h0200);
    clearn = 1'b0; startn = 1'b0; cyc(); cyc();
    clearn = 1'b1; startn = 1'b1; cyc();
    check("clr_start_state", state, 0);
    check("clr_start_disp", disp, 16'h0000);

    // Literal seconds above 59, and tens-of-minutes borrow
    key(4'd9); key(4'd9);
    press_start();
    tick(1); check("t0098", disp, 16'h0098);
    press_clear();
    key(4'd1); key(4'd0); key(4'd0); key(4'd0);
    press_start();
    tick(1); check("t0959", disp, 16'h0959);

    // Reset mid-cook
    reset = 1'b1; cyc();
    check("rst_mid_state", state, 0);
    check("rst_mid_disp", disp, 16'h0000);
    check("rst_mid_mag", mag_on, 0);
    cyc();
    check("rst_hold", state, 0);
    reset = 1'b0; cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
